// File: rtl/ncc_window_acc.sv
// Purpose : sliding-window accumulator for normalised cross-correlation. Loads a
//           WIN-pixel template row, then streams search pixels through a WIN-deep
//           window and reports sum_g, sum_g2, sum_fg (f.g), sum_f and sum_f2 per offset.
// Latency : 1 cycle from the accepted search pixel that completes a window to out_valid.
// Backpressure: a pending result holds in_ready low in STREAM until it is taken.
//           A take and a new accept in the same cycle reload with no bubble.
//
// Ports   : clk, rst_n (async active-low)
//           start                 begins a frame from IDLE
//           pix/in_valid/in_ready pixel stream (template f in LOAD_F, search g otherwise)
//           out_valid/out_ready   result handshake
//           sum_g, sum_g2, sum_fg, sum_f, sum_f2, offset, row   registered result
//           frame_sum_f, frame_sum_f2                          whole-frame template sums
//           busy, done            busy outside IDLE, one-cycle end-of-frame pulse
// Config  : define NCC_FG_CROSS_EN to build the f*g dot product. Without it sum_fg is 0.
//           ROWS and OFFSETS must be 2 or more.
module ncc_window_acc #(
  parameter int PIX_W   = 3,
  parameter int WIN     = 16,
  parameter int ROWS    = 16,
  parameter int OFFSETS = 64,
  localparam int LW  = $clog2(WIN),
  localparam int SW  = PIX_W + LW,
  localparam int QW  = 2*PIX_W + LW,
  localparam int OW  = $clog2(OFFSETS),
  localparam int RW  = $clog2(ROWS),
  localparam int FSW = SW + RW,
  localparam int FQW = QW + RW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] pix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    sum_g,
  output logic [QW-1:0]    sum_g2,
  output logic [QW-1:0]    sum_fg,
  output logic [SW-1:0]    sum_f,
  output logic [QW-1:0]    sum_f2,
  output logic [OW-1:0]    offset,
  output logic [RW-1:0]    row,
  output logic [FSW-1:0]   frame_sum_f,
  output logic [FQW-1:0]   frame_sum_f2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_F  = 3'd1,
    S_PRIME_G = 3'd2,
    S_STREAM  = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [LW-1:0]    cnt;
  logic [OW-1:0]    off_cnt;
  logic [RW-1:0]    row_cnt;
  logic [PIX_W-1:0] g_sr [WIN];   // g_sr[0] is the oldest pixel of the window
  logic [SW-1:0]    run_g, acc_f;
  logic [QW-1:0]    run_g2, acc_f2;

  logic [2*PIX_W-1:0] pix_x, old_x, pix_sq, old_sq;
  logic [SW-1:0]      run_g_nxt;
  logic [QW-1:0]      run_g2_nxt;
  logic [QW-1:0]      fg_nxt;

  logic pix_acc, stream_acc, start_go;
  logic f_last, p_last, o_last, r_last;
  logic shift_g, clear_row;

  assign pix_acc    = in_valid && in_ready;
  assign stream_acc = pix_acc && (state == S_STREAM);
  assign start_go   = (state == S_IDLE) && start;

  assign f_last = (cnt == LW'(WIN-1));
  assign p_last = (cnt == LW'(WIN-2));
  assign o_last = (off_cnt == OW'(OFFSETS-1));
  assign r_last = (row_cnt == RW'(ROWS-1));

  assign shift_g   = pix_acc && ((state == S_PRIME_G) || (state == S_STREAM));
  // Start of frame and start of each subsequent row both need a fresh window and template sums.
  assign clear_row = start_go || (stream_acc && o_last && !r_last);

  assign pix_x  = {{PIX_W{1'b0}}, pix};
  assign old_x  = {{PIX_W{1'b0}}, g_sr[0]};
  assign pix_sq = pix_x * pix_x;
  assign old_sq = old_x * old_x;

  // Running sums: the evicted slot is zero while priming, so the same update works throughout.
  // Intermediate wrap cancels because the final value always fits the width.
  assign run_g_nxt  = run_g + SW'(pix) - SW'(g_sr[0]);
  assign run_g2_nxt = run_g2 + QW'(pix_sq) - QW'(old_sq);

`ifdef NCC_FG_CROSS_EN
  logic [PIX_W-1:0] f_reg [WIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN; k++) f_reg[k] <= '0;
    end else if (pix_acc && (state == S_LOAD_F)) begin
      f_reg[cnt] <= pix;
    end
  end

  // Dot product over the window as it will be after this shift: f[k] meets g_sr[k+1],
  // and the newest slot is the incoming pixel.
  always_comb begin
    fg_nxt = QW'(f_reg[WIN-1]) * QW'(pix);
    for (int k = 0; k < WIN-1; k++) begin
      fg_nxt = fg_nxt + QW'(f_reg[k]) * QW'(g_sr[k+1]);
    end
  end
`else
  assign fg_nxt = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD_F;
      S_LOAD_F:  if (pix_acc && f_last) state_nxt = S_PRIME_G;
      S_PRIME_G: if (pix_acc && p_last) state_nxt = S_STREAM;
      S_STREAM:  if (pix_acc && o_last) state_nxt = r_last ? S_FIN : S_LOAD_F;
      S_FIN:     if (!out_valid) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_LOAD_F, S_PRIME_G: in_ready = 1'b1;
      S_STREAM:            in_ready = !out_valid || out_ready;
      S_FIN:               done     = !out_valid;
      default:             ;
    endcase
  end

  // Counters, window and template accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      off_cnt      <= '0;
      row_cnt      <= '0;
      run_g        <= '0;
      run_g2       <= '0;
      acc_f        <= '0;
      acc_f2       <= '0;
      frame_sum_f  <= '0;
      frame_sum_f2 <= '0;
      for (int k = 0; k < WIN; k++) g_sr[k] <= '0;
    end else begin
      if (start_go) begin
        row_cnt      <= '0;
        frame_sum_f  <= '0;
        frame_sum_f2 <= '0;
        cnt          <= '0;
        off_cnt      <= '0;
      end

      if (pix_acc && (state == S_LOAD_F)) begin
        if (f_last) begin
          cnt          <= '0;
          frame_sum_f  <= frame_sum_f  + FSW'(acc_f  + SW'(pix));
          frame_sum_f2 <= frame_sum_f2 + FQW'(acc_f2 + QW'(pix_sq));
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (pix_acc && (state == S_PRIME_G)) begin
        if (p_last) begin
          cnt     <= '0;
          off_cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (stream_acc) begin
        off_cnt <= o_last ? '0 : off_cnt + 1'b1;
        if (o_last && !r_last) row_cnt <= row_cnt + 1'b1;
      end

      if (clear_row) begin
        acc_f  <= '0;
        acc_f2 <= '0;
      end else if (pix_acc && (state == S_LOAD_F)) begin
        acc_f  <= acc_f  + SW'(pix);
        acc_f2 <= acc_f2 + QW'(pix_sq);
      end

      if (clear_row) begin
        run_g  <= '0;
        run_g2 <= '0;
        for (int k = 0; k < WIN; k++) g_sr[k] <= '0;
      end else if (shift_g) begin
        run_g  <= run_g_nxt;
        run_g2 <= run_g2_nxt;
        for (int k = 0; k < WIN-1; k++) g_sr[k] <= g_sr[k+1];
        g_sr[WIN-1] <= pix;
      end
    end
  end

  // Result register: held until taken, reloaded directly on take+accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum_g     <= '0;
      sum_g2    <= '0;
      sum_fg    <= '0;
      sum_f     <= '0;
      sum_f2    <= '0;
      offset    <= '0;
      row       <= '0;
    end else begin
      if (stream_acc) begin
        out_valid <= 1'b1;
        sum_g     <= run_g_nxt;
        sum_g2    <= run_g2_nxt;
        sum_fg    <= fg_nxt;
        sum_f     <= acc_f;
        sum_f2    <= acc_f2;
        offset    <= off_cnt;
        row       <= row_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ncc_window_acc.sv
module tb_ncc_window_acc;

  localparam int PIX_W = 3, WIN = 4, ROWS = 2, OFFSETS = 3;

`ifdef NCC_FG_CROSS_EN
  localparam bit FG_ON = 1'b1;
`else
  localparam bit FG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, out_ready;
  logic [2:0] pix;
  logic       in_ready, out_valid, busy, done;
  logic [4:0] sum_g, sum_f;
  logic [7:0] sum_g2, sum_fg, sum_f2;
  logic [1:0] offset;
  logic [0:0] row;
  logic [5:0] frame_sum_f;
  logic [8:0] frame_sum_f2;

  ncc_window_acc #(.PIX_W(PIX_W), .WIN(WIN), .ROWS(ROWS), .OFFSETS(OFFSETS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix(pix),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_g(sum_g), .sum_g2(sum_g2), .sum_fg(sum_fg),
    .sum_f(sum_f), .sum_f2(sum_f2), .offset(offset), .row(row),
    .frame_sum_f(frame_sum_f), .frame_sum_f2(frame_sum_f2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int e_sg;
    int e_sg2;
    int e_fg;
  } vec_t;

  vec_t vecs [3];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one pixel and hold it until accepted; returns just after the accepting edge.
  task automatic send(input int p);
    int t;
    @(negedge clk);
    pix      = 3'(p);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_in_time", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: normal row, mode 1: normal row with a 5-cycle out_ready stall, mode 2: all pixels 7
  task automatic do_row(input int mode, input int row_i);
    int gp, e_sg, e_sg2, e_fg;
    for (int k = 0; k < WIN; k++) send(mode == 2 ? 7 : k + 1);
    for (int k = 0; k < WIN-1; k++) send(mode == 2 ? 7 : 1);
    for (int i = 0; i < OFFSETS; i++) begin
      gp = (mode == 2) ? 7 : vecs[i].g;
      if (mode == 1 && i == 0) out_ready = 1'b0;
      if (mode == 1 && i == 1) begin
        pix      = 3'(gp);
        in_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_sum_g", int'(sum_g), 4);
          chk("stall_offset", int'(offset), 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
      end else begin
        send(gp);
      end
      @(negedge clk);
      e_sg  = (mode == 2) ? 28  : vecs[i].e_sg;
      e_sg2 = (mode == 2) ? 196 : vecs[i].e_sg2;
      e_fg  = FG_ON ? ((mode == 2) ? 196 : vecs[i].e_fg) : 0;
      chk("res_out_valid", int'(out_valid), 1);
      chk("res_sum_g", int'(sum_g), e_sg);
      chk("res_sum_g2", int'(sum_g2), e_sg2);
      chk("res_sum_fg", int'(sum_fg), e_fg);
      chk("res_sum_f", int'(sum_f), (mode == 2) ? 28 : 10);
      chk("res_sum_f2", int'(sum_f2), (mode == 2) ? 196 : 30);
      chk("res_offset", int'(offset), i);
      chk("res_row", int'(row), row_i);
    end
  endtask

  task automatic run_frame(input int m0, input int m1);
    int base, t;
    base = done_cnt;
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    chk("frame_f_cleared", int'(frame_sum_f), 0);
    do_row(m0, 0);
    do_row(m1, 1);
    chk("done_not_early", done_cnt - base, 0);
    t = 0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("busy_end", int'(busy), 0);
    chk("in_ready_idle", int'(in_ready), 0);
    chk("done_pulses", done_cnt - base, 1);
    chk("frame_sum_f", int'(frame_sum_f), ((m0 == 2) ? 28 : 10) + ((m1 == 2) ? 28 : 10));
    chk("frame_sum_f2", int'(frame_sum_f2), ((m0 == 2) ? 196 : 30) + ((m1 == 2) ? 196 : 30));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_sum_g"}, int'(sum_g), 0);
    chk({tag, "_sum_g2"}, int'(sum_g2), 0);
    chk({tag, "_sum_fg"}, int'(sum_fg), 0);
    chk({tag, "_sum_f"}, int'(sum_f), 0);
    chk({tag, "_sum_f2"}, int'(sum_f2), 0);
    chk({tag, "_offset"}, int'(offset), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_frame_f"}, int'(frame_sum_f), 0);
    chk({tag, "_frame_f2"}, int'(frame_sum_f2), 0);
  endtask

  initial begin
    // template 1,2,3,4; window primed with 1,1,1
    vecs[0] = '{g: 1, e_sg: 4, e_sg2: 4,  e_fg: 10};
    vecs[1] = '{g: 2, e_sg: 5, e_sg2: 7,  e_fg: 14};
    vecs[2] = '{g: 2, e_sg: 6, e_sg2: 10, e_fg: 17};

    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pix       = 3'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_frame(0, 0);   // basic row sent twice
    run_frame(1, 0);   // output stall in row 0
    run_frame(2, 2);   // full-scale pixels

    // Reset in the middle of priming row 1
    pulse_start();
    do_row(0, 0);
    for (int k = 0; k < WIN; k++) send(k + 1);
    send(1);
    send(1);
    @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_in_ready", int'(in_ready), 0);
    chk("post_reset_out_valid", int'(out_valid), 0);
    run_frame(0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ncc_window_acc.md
NCC_WINDOW_ACC -- requirements
Module: ncc_window_acc

Interface
REQ-001 Parameter PIX_W, default 3, pixel width in bits.
REQ-002 Parameter WIN, default 16, window/template width in pixels; must be 2 or more and a power of two.
REQ-003 Parameter ROWS, default 16, rows per frame.
REQ-004 Parameter OFFSETS, default 64, search offsets per row.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, begins a frame when sampled high in IDLE.
REQ-008 Port pix, input, PIX_W, pixel stream; the state decides whether it is a template (f) or search (g) pixel.
REQ-009 Port in_valid / in_ready, input / output, 1 each; a pixel is accepted when both are high.
REQ-010 Port out_valid / out_ready, output / input, 1 each; a result is taken when both are high.
REQ-011 Port sum_g, output, SW = PIX_W+log2(WIN); sum of the current g window.
REQ-012 Port sum_g2, output, QW = 2*PIX_W+log2(WIN); sum of squares of the current g window.
REQ-013 Port sum_fg, output, QW; dot product of the template and the g window.
REQ-014 Ports sum_f / sum_f2, output, SW / QW; sum and sum of squares of the current template row.
REQ-015 Ports offset / row, output, log2(OFFSETS) / log2(ROWS); tag of the current result.
REQ-016 Ports frame_sum_f / frame_sum_f2, output, SW+log2(ROWS) / QW+log2(ROWS); whole-frame template sums.
REQ-017 Ports busy / done, output, 1 each; busy is high outside IDLE; done is a one-cycle frame-end pulse.

Function
REQ-018 The FSM shall have the states IDLE, LOAD_F, PRIME_G, STREAM and FIN.
- IDLE to LOAD_F on start; start is ignored in every other state.
- On that transition, clear row, frame_sum_f and frame_sum_f2.
REQ-019 LOAD_F shall accept exactly WIN pixels into the template register.
- f[0] is the first pixel received.
- sum_f and sum_f2 accumulate as the pixels arrive.
- frame_sum_f and frame_sum_f2 are updated with the completed row sums.
- Then go to PRIME_G.
REQ-020 PRIME_G shall accept WIN-1 g pixels into the g shift register with no output, then go to STREAM with offset = 0.
REQ-021 In STREAM, each accepted g pixel completes a window. On the next rising edge the block shall:
- register sum_g, sum_g2, sum_fg, sum_f, sum_f2, offset and row;
- set out_valid.
Latency is therefore 1 cycle.
REQ-022 sum_g and sum_g2 shall be running sums: add the new pixel and subtract the evicted one. They shall not wrap within the stated widths.
REQ-023 sum_fg shall pair f[k] with the k-th oldest pixel of the g window, for k = 0..WIN-1.
REQ-024 in_ready shall be:
- 1 in LOAD_F and PRIME_G;
- 1 in STREAM only while out_valid is low or out_ready is high;
- 0 in IDLE and FIN.
REQ-025 out_valid shall stay high with all result outputs stable until taken. A simultaneous take and new accept shall reload without a bubble.
REQ-026 After the accept for offset OFFSETS-1:
- if row < ROWS-1, increment row, clear the g window and go to LOAD_F;
- otherwise go to FIN.
REQ-027 FIN shall wait until no result is pending, pulse done for one cycle, then enter IDLE. frame_sum_f and frame_sum_f2 shall hold until the next start.

Reset
REQ-028 rst_n low shall immediately force the following, including mid-frame:
- the FSM to IDLE;
- out_valid, in_ready, busy and done to 0;
- all sums, offset, row and both shift registers to 0.
REQ-029 Any pending result shall be discarded on reset. The first frame after release requires a new start.

Configuration
REQ-030 With macro NCC_FG_CROSS_EN defined, the WIN-term dot product shall be built and drive sum_fg.
REQ-031 With NCC_FG_CROSS_EN undefined, no multiplier for f*g shall exist and sum_fg shall be constant 0. All other behaviour and timing are unchanged.

Verification
The bench uses PIX_W=3, WIN=4, ROWS=2, OFFSETS=3 and NCC_FG_CROSS_EN defined unless stated.
REQ-032 Template 1,2,3,4; g = 1,1,1 (prime) then 1,2,2; out_ready=1.
- Expected results: (sum_g, sum_g2, sum_fg) = (4,4,10), (5,7,14), (6,10,17).
- sum_f = 10, sum_f2 = 30, offsets 0,1,2, row 0.
REQ-033 The REQ-032 row is sent twice.
- done pulses once after the 6th result.
- frame_sum_f = 20, frame_sum_f2 = 60.
REQ-034 out_ready is held 0 for 5 cycles during STREAM.
- in_ready is 0 and the result is unchanged throughout.
- No pixel is lost; the result sequence equals REQ-032.
REQ-035 All pixels are 7, giving a full-scale window.
- sum_g = 28, sum_g2 = 196, sum_fg = 196, with no overflow.
REQ-036 rst_n is pulsed low during PRIME_G of row 1.
- All outputs return to 0 and the FSM is in IDLE.
- A fresh start reproduces REQ-032 exactly.
REQ-037 With NCC_FG_CROSS_EN undefined, rerun REQ-032.
- sum_fg = 0; all other outputs are identical.
